xgmii_pktgen: RTL

- 64-bit XGMII transmit-side frame generator; drives the RX XGMII lanes of the measurement block (xgmii_N_rxd/rxc) with test Ethernet frames.
- Produces start/preamble/SFD, a fixed header, sequence number, timestamp, incrementing payload, FCS and terminate, with a programmable inter-frame gap.
- Used as the stimulus source for latency/throughput measurement, in simulation and on-board loopback.

---
 rtl/xgmii_pktgen.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/xgmii_pktgen.sv
// rtl/xgmii_pktgen.sv - 64-bit XGMII transmit test-frame generator
// Define XGMII_PKTGEN_CRC_EN to fill the FCS with Ethernet CRC-32 (zeros otherwise)
module xgmii_pktgen #(
  parameter logic [47:0] SRC_MAC   = 48'h001122334455,
  parameter logic [15:0] ETHERTYPE = 16'h3776,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_len,
  input  logic [31:0] pkt_count,
  input  logic [7:0]  ifg_cycles,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        busy,
  output logic        done,
  output logic [31:0] tx_count
);
  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TERM, S_GAP} state_t;
  state_t r_state, w_next;

  logic [15:0] r_len;
  logic [31:0] r_pkts, r_seq, r_ts, r_cyc;
  logic [7:0]  r_ifg, r_widx, r_gcnt;
  logic        r_stop;
  logic [15:0] w_len_clamp, w_last_idx, w_fcs_start, w_k;
  logic [2:0]  w_rem;
  logic        w_last, w_run_end;
  logic [63:0] w_txd;
  logic [7:0]  w_txc;
  logic [31:0] w_fcs;

  assign w_len_clamp = (frame_len < 16'(MIN_LEN)) ? 16'(MIN_LEN) :
                       (frame_len > 16'(MAX_LEN)) ? 16'(MAX_LEN) : frame_len;
  assign w_last_idx  = ((r_len + 16'd7) >> 3) - 16'd1;
  assign w_last      = ({8'd0, r_widx} == w_last_idx);
  assign w_rem       = r_len[2:0];
  assign w_fcs_start = r_len - 16'd4;
  assign w_run_end   = r_stop || stop || ((r_pkts != 32'd0) && (tx_count == r_pkts));

  // Non-FCS frame byte at offset k (header fields are big-endian)
  function automatic logic [7:0] f_byte(input logic [15:0] k, input logic [31:0] seq,
                                        input logic [31:0] ts);
    if (k < 16'd6)       return 8'hFF;
    else if (k < 16'd12) return 8'(SRC_MAC >> (8 * (11 - int'(k))));
    else if (k == 16'd12) return ETHERTYPE[15:8];
    else if (k == 16'd13) return ETHERTYPE[7:0];
    else if (k < 16'd18) return 8'(seq >> (8 * (17 - int'(k))));
    else if (k < 16'd22) return 8'(ts >> (8 * (21 - int'(k))));
    else                 return k[7:0];
  endfunction

`ifdef XGMII_PKTGEN_CRC_EN
  logic [31:0] r_crc, w_crc;

  function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction
`endif

  always_comb begin
    w_next = r_state;
    w_txd  = IDLE_WORD;
    w_txc  = 8'hFF;
    w_fcs  = 32'd0;
    w_k    = 16'd0;
`ifdef XGMII_PKTGEN_CRC_EN
    w_crc  = r_crc;
`endif
    case (r_state)
      S_IDLE:  if (start) w_next = S_START;
      S_START: begin
        w_txd  = START_WORD;
        w_txc  = 8'h01;
        w_next = S_DATA;
      end
      S_DATA: begin
`ifdef XGMII_PKTGEN_CRC_EN
        // FCS bytes may sit in the same word as the last data bytes, so fold them in first
        for (int l = 0; l < 8; l++) begin
          w_k = {5'd0, r_widx, 3'(l)};
          if (w_k < w_fcs_start) w_crc = f_crc8(w_crc, f_byte(w_k, r_seq, r_ts));
        end
        w_fcs = ~w_crc;
`endif
        for (int l = 0; l < 8; l++) begin
          w_k = {5'd0, r_widx, 3'(l)};
          if (w_last && (w_rem != 3'd0) && (3'(l) >= w_rem)) begin
            w_txd[8*l +: 8] = (3'(l) == w_rem) ? 8'hFD : 8'h07;
          end else begin
            w_txc[l]        = 1'b0;
            w_txd[8*l +: 8] = (w_k >= w_fcs_start) ?
                              8'(w_fcs >> (8 * int'(w_k - w_fcs_start))) :
                              f_byte(w_k, r_seq, r_ts);
          end
        end
        if (w_last) w_next = (w_rem == 3'd0) ? S_TERM : S_GAP;
      end
      S_TERM: begin
        w_txd  = TERM_WORD;
        w_next = S_GAP;
      end
      S_GAP:   if (r_gcnt == 8'd0) w_next = w_run_end ? S_IDLE : S_START;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      xgmii_txd <= IDLE_WORD;
      xgmii_txc <= 8'hFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      tx_count  <= 32'd0;
      r_len     <= 16'd0;
      r_pkts    <= 32'd0;
      r_ifg     <= 8'd0;
      r_seq     <= 32'd0;
      r_ts      <= 32'd0;
      r_cyc     <= 32'd0;
      r_widx    <= 8'd0;
      r_gcnt    <= 8'd0;
      r_stop    <= 1'b0;
`ifdef XGMII_PKTGEN_CRC_EN
      r_crc     <= 32'hFFFFFFFF;
`endif
    end else begin
      xgmii_txd <= w_txd;
      xgmii_txc <= w_txc;
      r_cyc     <= r_cyc + 32'd1;
      done      <= 1'b0;
      if (busy && stop) r_stop <= 1'b1;
      case (r_state)
        S_IDLE: if (start) begin
          r_len    <= w_len_clamp;
          r_pkts   <= pkt_count;
          r_ifg    <= ifg_cycles;
          r_seq    <= 32'd0;
          tx_count <= 32'd0;
          r_stop   <= 1'b0;
          busy     <= 1'b1;
        end
        S_START: begin
          r_ts   <= r_cyc;
          r_widx <= 8'd0;
`ifdef XGMII_PKTGEN_CRC_EN
          r_crc  <= 32'hFFFFFFFF;
`endif
        end
        S_DATA: begin
          r_widx <= r_widx + 8'd1;
`ifdef XGMII_PKTGEN_CRC_EN
          r_crc  <= w_crc;
`endif
        end
        S_GAP: begin
          if (r_gcnt != 8'd0) begin
            r_gcnt <= r_gcnt - 8'd1;
          end else if (w_run_end) begin
            done   <= 1'b1;
            busy   <= 1'b0;
            r_stop <= 1'b0;
          end
        end
        default: ;
      endcase
      // A frame counts as sent the moment its gap begins
      if ((w_next == S_GAP) && (r_state != S_GAP)) begin
        tx_count <= (tx_count == 32'hFFFFFFFF) ? tx_count : tx_count + 32'd1;
        r_seq    <= r_seq + 32'd1;
        r_gcnt   <= (r_ifg == 8'd0) ? 8'd0 : r_ifg - 8'd1;
      end
    end
  end
endmodule
